dem_rr_ctrl: RTL and testbench

DEM_RR_CTRL -- requirements
Module: dem_rr_ctrl

---
 rtl/dem_rr_ctrl_if.sv | 8 +
 rtl/dem_rr_ctrl.sv | 50 +++++
 tb/tb_dem_rr_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dem_rr_ctrl_if.sv
// dem_rr_ctrl_if: serial input handshake plus routed outputs of the round-robin demux controller
interface dem_rr_ctrl_if;
  logic f, valid, ready, a, b, c, d, wrap;
  logic [3:0] en, out_vld;
  logic [1:0] s;
  modport master(output f, valid, en, input ready, s, a, b, c, d, out_vld, wrap);
  modport slave(input f, valid, en, output ready, s, a, b, c, d, out_vld, wrap);
endinterface

// File: rtl/dem_rr_ctrl.sv
// dem_rr_ctrl: routes a serial bit stream to enabled channels a..d in bursts of BURST, round-robin
module dem_rr_ctrl #(
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst_n,
  dem_rr_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t st, st_n;
  logic [1:0] s, s_n, adv, first;
  logic [3:0] cnt, cnt_n, sel, vld, dat;
  logic rdy, xfer, last, wrap;
  // first enabled channel at base, base+1, base+2, base+3 (mod 4); fb when none
  function automatic logic [1:0] seek(input logic [1:0] base, input logic [3:0] m, input logic [1:0] fb);
    seek = fb;
    for (int i = 3; i >= 0; i--) if (m[base + 2'(i)]) seek = base + 2'(i);
  endfunction
  assign sel = 4'b1 << s;
  assign rdy = st == RUN && bus.en[s];
  assign xfer = bus.valid && rdy;
  assign last = cnt == 4'(BURST - 1);
  assign adv = seek(s + 2'd1, bus.en & ~sel, s);
  assign first = seek(s, bus.en, s);
  assign st_n = |bus.en ? RUN : IDLE;
  assign s_n = st == IDLE ? first : !bus.en[s] ? adv : xfer && last ? adv : s;
  assign cnt_n = rdy ? (xfer ? (last ? 4'd0 : cnt + 4'd1) : cnt) : 4'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      s <= 2'd0;
      cnt <= 4'd0;
      vld <= 4'd0;
      dat <= 4'd0;
      wrap <= 1'b0;
    end else begin
      st <= st_n;
      s <= s_n;
      cnt <= cnt_n;
      vld <= xfer ? sel : 4'd0;
      dat <= xfer && bus.f ? sel : 4'd0;
      wrap <= s_n < s;
    end
  end
  assign bus.ready = rdy;
  assign bus.s = s;
  assign bus.out_vld = vld;
  assign bus.wrap = wrap;
  assign {bus.d, bus.c, bus.b, bus.a} = dat;
endmodule

// File: tb/tb_dem_rr_ctrl.sv
// tb_dem_rr_ctrl: directed vectors with a queued scoreboard checked by a separate output monitor
module tb_dem_rr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  dem_rr_ctrl_if i4();
  dem_rr_ctrl_if i2();
  dem_rr_ctrl_if i1();
  dem_rr_ctrl #(.BURST(4)) u4(.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  dem_rr_ctrl #(.BURST(2)) u2(.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  dem_rr_ctrl #(.BURST(1)) u1(.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  typedef struct packed {logic [1:0] dut; logic [8:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask
  // {wrap, out_vld, d, c, b, a}
  function automatic logic [8:0] obs(input int d);
    return d == 0 ? {i4.wrap, i4.out_vld, i4.d, i4.c, i4.b, i4.a} :
           d == 1 ? {i2.wrap, i2.out_vld, i2.d, i2.c, i2.b, i2.a} :
                    {i1.wrap, i1.out_vld, i1.d, i1.c, i1.b, i1.a};
  endfunction
  function automatic logic rdy(input int d);
    return d == 0 ? i4.ready : d == 1 ? i2.ready : i1.ready;
  endfunction
  task automatic drive(input int d, input logic [3:0] en, input logic v, input logic f);
    case (d)
      0: begin i4.en = en; i4.valid = v; i4.f = f; end
      1: begin i2.en = en; i2.valid = v; i2.f = f; end
      default: begin i1.en = en; i1.valid = v; i1.f = f; end
    endcase
  endtask
  task automatic step(input int d, input logic [3:0] en, input logic v, input logic f,
                      input logic rdy_e, input int ch, input logic wr, input logic push = 1'b1);
    logic [3:0] oh;
    drive(d, en, v, f);
    #1 chk($sformatf("ready dut%0d", d), rdy(d), rdy_e);
    oh = (v && rdy_e) ? 4'(1 << ch) : 4'd0;
    if (push && (wr || |oh)) sb.push_back({2'(d), wr, oh, f ? oh : 4'd0});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    for (int d = 0; d < 3; d++)
      if (obs(d) != 9'd0) begin
        if (sb.size() == 0) chk($sformatf("unexpected out dut%0d", d), obs(d), 0);
        else begin
          e = sb.pop_front();
          chk("scoreboard dut", d, e.dut);
          chk($sformatf("outputs dut%0d", d), obs(d), e.v);
        end
      end
  initial begin
    drive(0, 4'd0, 1'b0, 1'b0);
    drive(1, 4'd0, 1'b0, 1'b0);
    drive(2, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2 chk("reset s", i4.s, 0);
    chk("reset out_vld", i4.out_vld, 0);
    chk("reset wrap", i4.wrap, 0);
    chk("reset data", {i4.a, i4.b, i4.c, i4.d}, 0);
    chk("reset ready", i4.ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // full rotation over all four channels
    step(0, 4'hf, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 4'hf, 1'b1, 1'b1, 1'b1, i / 4, i == 15);
    chk("s after rotation", i4.s, 0);
    // disable b mid-burst: skip to c with the count cleared
    for (int i = 0; i < 4; i++) step(0, 4'hf, 1'b1, i[0], 1'b1, 0, 1'b0);
    for (int i = 0; i < 2; i++) step(0, 4'hf, 1'b1, !i[0], 1'b1, 1, 1'b0);
    step(0, 4'b1101, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("s after b disabled", i4.s, 2);
    step(0, 4'b1101, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    step(0, 4'b1101, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    chk("s mid c burst", i4.s, 2);
    chk("c strobe", i4.out_vld, 4'b0100);
    // asynchronous reset pulse mid-burst
    drive(0, 4'hf, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async reset out_vld", i4.out_vld, 0);
    chk("async reset c", i4.c, 0);
    chk("async reset s", i4.s, 0);
    #1 rst_n = 1'b1;
    step(0, 4'hf, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 4'hf, 1'b1, i < 2, 1'b1, 0, 1'b0);
    chk("s after a burst", i4.s, 1);
    // all channels disabled, then only d
    step(0, 4'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("s held in idle", i4.s, 1);
    step(0, 4'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(0, 4'b1000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("s to d", i4.s, 3);
    for (int i = 0; i < 3; i++) step(0, 4'b1000, 1'b1, i != 1, 1'b1, 3, 1'b0);
    // d disabled, only a left: jump wraps with no data
    step(0, 4'b0001, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    chk("s wrap to a", i4.s, 0);
    step(0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // BURST=2 alternating a and c
    step(1, 4'b0101, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1, 4'b0101, 1'b1, !i[0], 1'b1, ((i / 2) % 2) ? 2 : 0, i == 3);
    chk("burst2 s", i2.s, 2);
    step(1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // BURST=1 single channel b, valid toggling
    step(2, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("burst1 s start", i1.s, 1);
    for (int i = 0; i < 6; i++) step(2, 4'b0010, !i[0], i != 2, 1'b1, 1, 1'b0);
    chk("burst1 s hold", i1.s, 1);
    step(2, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
